// File: rtl/noc_msg_fifo_pkg.sv
// Shared constants for the NoC message FIFO: flit width, header length field, ingress FSM encodings.
package noc_msg_fifo_pkg;

  localparam int NOC_DATA_WIDTH   = 64;
  localparam int MSG_LENGTH_LSB   = 22;
  localparam int MSG_LENGTH_WIDTH = 8;

  typedef enum logic [1:0] {
    NOC_MSG_FIFO_IDLE = 2'd0,
    NOC_MSG_FIFO_RECV = 2'd1,
    NOC_MSG_FIFO_DROP = 2'd2
  } noc_msg_fifo_state_t;

endpackage

// File: rtl/noc_msg_fifo_ram.sv
// Simple dual-port flit storage with registered read; a same-cycle write to the read address
// is forwarded into the read register so a freshly committed single-flit message is visible at once.
module noc_msg_fifo_ram
  import noc_msg_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/noc_msg_fifo.sv
// Store-and-forward NoC message FIFO: messages become visible only once their last flit is written.
// Optional NOC_MSG_FIFO_STATS_EN adds the msg_count port.
//   state | meaning
//   IDLE  | expecting a header flit; space for the whole message reserved here
//   RECV  | storing payload flits of an accepted message
//   DROP  | discarding payload of an oversize message
module noc_msg_fifo
  import noc_msg_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = NOC_DATA_WIDTH,
  parameter int DEPTH_FLITS = 16,
  parameter int MAX_MSGS    = 4,
  parameter int LEN_LSB     = MSG_LENGTH_LSB,
  parameter int LEN_WIDTH   = MSG_LENGTH_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  err_oversize
`ifdef NOC_MSG_FIFO_STATS_EN
  , output logic [$clog2(MAX_MSGS):0] msg_count
`endif
);

  localparam int AW  = $clog2(DEPTH_FLITS);
  localparam int RAW = (MAX_MSGS > 1) ? $clog2(MAX_MSGS) : 1;
  localparam int NW  = LEN_WIDTH + 1;

  noc_msg_fifo_state_t state_q, state_d;
  logic [LEN_WIDTH-1:0] remain_q, remain_d;
  logic [AW:0]          wr_ptr, rd_ptr, cm_ptr, need_q, rd_off, free_flits, commit_need, head_need;
  logic [RAW:0]         rec_wr, rec_rd, rec_used;
  logic [AW:0]          rec_mem [2**RAW];
  logic [LEN_WIDTH-1:0] hdr_len;
  logic [NW-1:0]        need;
  logic                 oversize, space_ok, rdy, store, commit, drop_hdr;
  logic                 in_fire, out_fire, last_out, err_q;
  logic [AW-1:0]        raddr;

  assign hdr_len    = data_in[LEN_LSB +: LEN_WIDTH];
  assign need       = {1'b0, hdr_len} + NW'(1);
  assign oversize   = 32'(need) > 32'(DEPTH_FLITS);
  assign free_flits = (AW+1)'(DEPTH_FLITS) - (wr_ptr - rd_ptr);
  assign rec_used   = rec_wr - rec_rd;
  assign space_ok   = (32'(need) <= 32'(free_flits)) && (32'(rec_used) < 32'(MAX_MSGS));

  assign ready_in = rdy && rst_n;
  assign in_fire  = valid_in && ready_in;
  assign out_fire = valid_out && ready_out;

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    rdy         = 1'b0;
    store       = 1'b0;
    commit      = 1'b0;
    drop_hdr    = 1'b0;
    commit_need = need_q;
    case (state_q)
      NOC_MSG_FIFO_IDLE: begin
        rdy = oversize || space_ok;
        if (in_fire) begin
          remain_d = hdr_len;
          if (oversize) begin
            drop_hdr = 1'b1;
            if (hdr_len != '0) state_d = NOC_MSG_FIFO_DROP;
          end else begin
            store = 1'b1;
            if (hdr_len == '0) begin
              commit      = 1'b1;
              commit_need = (AW+1)'(1);
            end else begin
              state_d = NOC_MSG_FIFO_RECV;
            end
          end
        end
      end
      NOC_MSG_FIFO_RECV: begin
        rdy = 1'b1;
        if (in_fire) begin
          store    = 1'b1;
          remain_d = remain_q - LEN_WIDTH'(1);
          if (remain_q == LEN_WIDTH'(1)) begin
            commit  = 1'b1;
            state_d = NOC_MSG_FIFO_IDLE;
          end
        end
      end
      NOC_MSG_FIFO_DROP: begin
        rdy = 1'b1;
        if (in_fire) begin
          remain_d = remain_q - LEN_WIDTH'(1);
          if (remain_q == LEN_WIDTH'(1)) state_d = NOC_MSG_FIFO_IDLE;
        end
      end
      default: state_d = NOC_MSG_FIFO_IDLE;
    endcase
  end

  // Egress: visible flits are those below the commit pointer; records mark message boundaries.
  assign valid_out = (cm_ptr != rd_ptr);
  assign head_need = rec_mem[rec_rd[RAW-1:0]];
  assign last_out  = out_fire && (rd_off == head_need - (AW+1)'(1));
  assign raddr     = out_fire ? rd_ptr[AW-1:0] + AW'(1) : rd_ptr[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= NOC_MSG_FIFO_IDLE;
      remain_q <= '0;
      need_q   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cm_ptr   <= '0;
      rd_off   <= '0;
      rec_wr   <= '0;
      rec_rd   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      err_q    <= drop_hdr;
      if (state_q == NOC_MSG_FIFO_IDLE && in_fire) need_q <= (AW+1)'(need);
      if (store)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (commit) begin
        cm_ptr <= wr_ptr + (AW+1)'(1);
        rec_wr <= rec_wr + (RAW+1)'(1);
      end
      if (out_fire) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        if (last_out) begin
          rd_off <= '0;
          rec_rd <= rec_rd + (RAW+1)'(1);
        end else begin
          rd_off <= rd_off + (AW+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit) rec_mem[rec_wr[RAW-1:0]] <= commit_need;
  end

  assign err_oversize = err_q;

`ifdef NOC_MSG_FIFO_STATS_EN
  logic [$clog2(MAX_MSGS):0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt_q <= '0;
    else if (commit && !last_out) cnt_q <= cnt_q + 1'b1;
    else if (!commit && last_out) cnt_q <= cnt_q - 1'b1;
  end
  assign msg_count = cnt_q;
`endif

  noc_msg_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH_FLITS)
  ) u_ram (
    .clk   (clk),
    .we    (store),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_in),
    .raddr (raddr),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_noc_msg_fifo.sv
// Directed bench for noc_msg_fifo with a transaction-level message model checked every cycle.
module tb_noc_msg_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic [63:0] data_out;
  logic        valid_out;
  logic        ready_out = 1'b0;
  logic        err_oversize;
`ifdef NOC_MSG_FIFO_STATS_EN
  logic [2:0]  msg_count;
`endif

  always #5 clk = ~clk;

  noc_msg_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_in     (ready_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_out    (ready_out),
    .err_oversize (err_oversize)
`ifdef NOC_MSG_FIFO_STATS_EN
    , .msg_count  (msg_count)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  logic        vin = 1'b0;
  logic        rout = 1'b0;
  logic [63:0] din = '0;
  bit          fired_in, fired_out;

  logic [63:0] exp_q[$];
  logic [63:0] pend[$];
  int          msg_q[$];
  int          m_state = 0;
  int          m_rem = 0;
  bit          err_exp = 1'b0;
  int          n_out = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] hdr(input int id, input int len);
    return (64'(id) << 32) | (64'(len) << 22);
  endfunction

  function automatic logic [63:0] pay(input int id, input int idx);
    return (64'(id) << 32) | 64'h8000_0000 | 64'(idx);
  endfunction

  task automatic commit_model();
    msg_q.push_back(pend.size());
    foreach (pend[i]) exp_q.push_back(pend[i]);
    pend.delete();
  endtask

  // One clock: apply staged inputs at negedge, check outputs, then advance the model.
  task automatic cyc();
    int len;
    bit err_nxt;
    @(negedge clk);
    valid_in  = vin;
    data_in   = din;
    ready_out = rout;
    #1;
    chk("valid_out", 64'(valid_out), 64'(exp_q.size() != 0));
    chk("err_oversize", 64'(err_oversize), 64'(err_exp));
`ifdef NOC_MSG_FIFO_STATS_EN
    chk("msg_count", 64'(msg_count), 64'(msg_q.size()));
`endif
    if (valid_out && exp_q.size() != 0) chk("data_out", data_out, exp_q[0]);
    fired_in  = valid_in && ready_in;
    fired_out = valid_out && ready_out;
    err_nxt   = 1'b0;
    if (fired_out && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      n_out++;
      msg_q[0] = msg_q[0] - 1;
      if (msg_q[0] == 0) void'(msg_q.pop_front());
    end
    if (fired_in) begin
      case (m_state)
        0: begin
          len = int'(data_in[29:22]);
          if (len + 1 > 16) begin
            err_nxt = 1'b1;
            if (len != 0) begin m_state = 2; m_rem = len; end
          end else begin
            pend.push_back(data_in);
            if (len == 0) commit_model();
            else begin m_state = 1; m_rem = len; end
          end
        end
        1: begin
          pend.push_back(data_in);
          m_rem--;
          if (m_rem == 0) begin commit_model(); m_state = 0; end
        end
        default: begin
          m_rem--;
          if (m_rem == 0) m_state = 0;
        end
      endcase
    end
    err_exp = err_nxt;
  endtask

  task automatic send(input logic [63:0] flit);
    bit ok;
    ok  = 1'b0;
    vin = 1'b1;
    din = flit;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (fired_in) begin ok = 1'b1; break; end
    end
    chk("send_accept", 64'(ok), 64'(1));
    vin = 1'b0;
  endtask

  task automatic drain(input int bound);
    vin  = 1'b0;
    rout = 1'b1;
    for (int i = 0; i < bound && exp_q.size() != 0; i++) cyc();
    cyc();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    rout = 1'b0;
  endtask

  initial begin
    logic [63:0] flits[$];
    int idx, len, out0;

    // Reset state
    #2;
    chk("rst_ready_in", 64'(ready_in), 64'(0));
    chk("rst_valid_out", 64'(valid_out), 64'(0));
    chk("rst_err", 64'(err_oversize), 64'(0));
`ifdef NOC_MSG_FIFO_STATS_EN
    chk("rst_msg_count", 64'(msg_count), 64'(0));
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: 3-flit message invisible until its last flit is in
    rout = 1'b0;
    send(hdr(1, 2));
    send(pay(1, 0));
    chk("t1_partial_hidden", 64'(valid_out), 64'(0));
    send(pay(1, 1));
    out0 = n_out;
    drain(10);
    chk("t1_out_count", 64'(n_out - out0), 64'(3));

    // 2: record limit stalls fifth header until one record frees
    for (int m = 0; m < 4; m++) send(hdr(10 + m, 0));
    vin = 1'b1;
    din = hdr(14, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_stall_ready", 64'(ready_in), 64'(0));
    end
    rout = 1'b1;
    cyc();
    chk("t2_no_accept_while_full", 64'(fired_in), 64'(0));
    rout = 1'b0;
    cyc();
    chk("t2_accept_after_read", 64'(fired_in), 64'(1));
    vin = 1'b0;
    drain(20);

    // 3: 16-flit message fills storage; next header waits for a read
    send(hdr(20, 15));
    for (int i = 0; i < 15; i++) send(pay(20, i));
    vin = 1'b1;
    din = hdr(21, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_full_stall", 64'(ready_in), 64'(0));
    end
    rout = 1'b1;
    cyc();
    rout = 1'b0;
    cyc();
    chk("t3_accept_after_read", 64'(fired_in), 64'(1));
    vin = 1'b0;
    drain(40);

    // 4: oversize header (need 21) dropped with its payload
    out0 = n_out;
    send(hdr(30, 20));
    chk("t4_err_next_cycle", 64'(err_oversize), 64'(0));
    for (int i = 0; i < 20; i++) send(pay(30, i));
    chk("t4_model_idle", 64'(m_state), 64'(0));
    drain(10);
    chk("t4_nothing_out", 64'(n_out - out0), 64'(0));

    // 5: random handshakes, 1000 messages of length 0..7
    for (int m = 0; m < 1000; m++) begin
      len = $urandom_range(7);
      flits.push_back(hdr(100 + m, len));
      for (int i = 0; i < len; i++) flits.push_back(pay(100 + m, i));
    end
    out0 = n_out;
    idx  = 0;
    vin  = 1'b0;
    for (int c = 0; c < 60000 && idx < flits.size(); c++) begin
      if (!vin && $urandom_range(3) != 0) begin
        vin = 1'b1;
        din = flits[idx];
      end
      rout = 1'($urandom_range(1));
      cyc();
      if (fired_in) begin
        idx++;
        vin = 1'b0;
      end
    end
    chk("t5_all_sent", 64'(idx), 64'(flits.size()));
    drain(200);
    chk("t5_all_received", 64'(n_out - out0), 64'(flits.size()));

    // 6: reset in the middle of a message discards it
    send(hdr(40, 3));
    send(pay(40, 0));
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    vin      = 1'b0;
    #1;
    chk("t6_rst_valid_out", 64'(valid_out), 64'(0));
    chk("t6_rst_ready_in", 64'(ready_in), 64'(0));
`ifdef NOC_MSG_FIFO_STATS_EN
    chk("t6_rst_msg_count", 64'(msg_count), 64'(0));
`endif
    exp_q.delete();
    pend.delete();
    msg_q.delete();
    m_state = 0;
    err_exp = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out0 = n_out;
    send(hdr(41, 1));
    send(pay(41, 0));
    drain(10);
    chk("t6_clean_msg_out", 64'(n_out - out0), 64'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
